// File: rtl/bin_window_gen.sv
// Sliding 7x7 window generator over a raster stream of binarized pixels.
// Six single-bit line buffers feed a 7x7 shift window behind a valid/ready port.
module bin_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_pix,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [48:0] out_win,
    output logic [7:0]  out_row,
    output logic [7:0]  out_col,
    output logic        frame_done
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] LAST_C = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_R = 8'(IMG_H - 1);

    logic [7:0]       r_col;
    logic [7:0]       r_row;
    logic [IMG_W-1:0] r_lb [6];
    logic [6:0]       r_win [7];
    logic             r_valid;
    logic             r_done;
    logic [7:0]       r_orow;
    logic [7:0]       r_ocol;

    logic          w_acc;
    logic          w_emit;
    logic          w_last_c;
    logic          w_last;
    logic [7:0]    w_c;
    logic [7:0]    w_r;
    logic [7:0]    w_col_nxt;
    logic [7:0]    w_row_nxt;
    logic [AW-1:0] w_ci;

    // Held high through reset so upstream never stalls on a stale out_valid.
    assign in_ready = rst || !r_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    // An SOF pixel is position (0,0) whatever the counters say.
    assign w_c  = in_sof ? 8'd0 : r_col;
    assign w_r  = in_sof ? 8'd0 : r_row;
    assign w_ci = w_c[AW-1:0];

    assign w_last_c = (w_c == LAST_C);
    assign w_last   = w_last_c && (w_r == LAST_R);
    assign w_emit   = w_acc && (w_r >= 8'd6) && (w_c >= 8'd6);

    always_comb begin
        w_col_nxt = w_c + 8'd1;
        w_row_nxt = w_r;
        if (w_last_c) begin
            w_col_nxt = 8'd0;
            w_row_nxt = w_last ? 8'd0 : w_r + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_orow  <= '0;
            r_ocol  <= '0;
            for (int i = 0; i < 6; i++) r_lb[i] <= '0;
            for (int i = 0; i < 7; i++) r_win[i] <= '0;
        end else begin
            r_done <= w_acc && w_last;
            if (w_acc) begin
                r_col   <= w_col_nxt;
                r_row   <= w_row_nxt;
                r_valid <= w_emit;
                r_lb[0][w_ci] <= in_pix;
                for (int i = 1; i < 6; i++)
                    r_lb[i][w_ci] <= r_lb[i-1][w_ci];
                r_win[0] <= {r_win[0][5:0], in_pix};
                for (int i = 1; i < 7; i++)
                    r_win[i] <= {r_win[i][5:0], r_lb[i-1][w_ci]};
                if (w_emit) begin
                    r_orow <= w_r - 8'd6;
                    r_ocol <= w_c - 8'd6;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        out_win = '0;
        for (int i = 0; i < 7; i++)
            out_win[7*i +: 7] = r_win[i];
    end

    assign out_valid  = r_valid;
    assign out_row    = r_orow;
    assign out_col    = r_ocol;
    assign frame_done = r_done;

endmodule

// File: tb/tb_bin_window_gen.sv
// Directed bench for bin_window_gen: 28x28 instance plus a 7x7 minimum-size one.
// Expected windows come from the bench's own image array.
module tb_bin_window_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_pix = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [48:0] out_win;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        frame_done;

    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic        m_in_pix = 1'b0;
    logic        m_in_sof = 1'b0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [48:0] m_out_win;
    logic [7:0]  m_out_row;
    logic [7:0]  m_out_col;
    logic        m_frame_done;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          acc;
    bit          img [0:27][0:27];
    logic [48:0] first_win;

    always #5 clk = ~clk;

    bin_window_gen #(.IMG_W(28), .IMG_H(28)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_win(out_win), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    bin_window_gen #(.IMG_W(7), .IMG_H(7)) u_min (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_pix(m_in_pix), .in_sof(m_in_sof),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_win(m_out_win), .out_row(m_out_row), .out_col(m_out_col),
        .frame_done(m_frame_done)
    );

    function automatic logic [48:0] gold(input int R, input int C);
        logic [48:0] w;
        w = '0;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                w[7*i+j] = img[R+6-i][C+6-j];
        return w;
    endfunction

    task automatic fill_img(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                case (mode)
                    0: img[r][c] = 1'($urandom_range(0, 1));
                    1: img[r][c] = (r == 3 && c == 2);
                    default: img[r][c] = 1'((r ^ c) & 1);
                endcase
    endtask

    task automatic cyc(input bit v, input bit p, input bit s, input bit rdy);
        @(negedge clk);
        in_valid = v;
        in_pix = p;
        in_sof = s;
        out_ready = rdy;
        #1 acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit sof, input int stall);
        int k, kk, er, ec, nwin, nfd, st, g;
        bit seen, rdy, pv;
        logic [48:0] pw;
        logic [7:0] pr, pc;
        k = 0; er = 0; ec = 0; nwin = 0; nfd = 0; st = 0; g = 0;
        seen = 0;
        while ((k < 784 || out_valid) && g < 4000) begin
            rdy = (st == 0);
            if (st > 0) st--;
            pv = out_valid;
            pw = out_win;
            pr = out_row;
            pc = out_col;
            kk = (k < 784) ? k : 0;
            cyc(k < 784, img[kk/28][kk%28], sof && k == 0, rdy);
            if (pv && rdy) begin
                n_chk++;
                if (nwin >= 484) begin
                    n_fail++;
                    $display("FAIL extra_window: got row %0d col %0d, want none",
                             pr, pc);
                end else if (pw !== gold(er, ec) || pr !== 8'(er) ||
                             pc !== 8'(ec)) begin
                    n_fail++;
                    $display("FAIL window_%0d: got r%0d c%0d %h, want r%0d c%0d %h",
                             nwin, pr, pc, pw, er, ec, gold(er, ec));
                end
                if (nwin == 0) first_win = pw;
                nwin++;
                if (ec == 21) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            if (!rdy) begin
                n_chk++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_win !== pw ||
                    out_row !== pr || out_col !== pc) begin
                    n_fail++;
                    $display("FAIL stall_hold: got rdy %b v %b r%0d c%0d %h, want 0 1 r%0d c%0d %h",
                             in_ready, out_valid, out_row, out_col, out_win, pr, pc, pw);
                end
            end
            if (acc) k++;
            if (out_valid && !seen) begin
                seen = 1;
                st = stall;
                n_chk++;
                if (k !== 175) begin
                    n_fail++;
                    $display("FAIL first_latency: got %0d pixels, want 175", k);
                end
            end
            if (frame_done) begin
                nfd++;
                n_chk++;
                if (out_valid !== 1'b1 || out_row !== 8'd21 || out_col !== 8'd21) begin
                    n_fail++;
                    $display("FAIL done_window: got v %b r%0d c%0d, want 1 r21 c21",
                             out_valid, out_row, out_col);
                end
            end
            g++;
        end
        n_chk++;
        if (nwin != 484 || nfd != 1 || g >= 4000) begin
            n_fail++;
            $display("FAIL frame_totals: got %0d windows %0d done %0d cycles, want 484 1 <4000",
                     nwin, nfd, g);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_win !== '0 || out_row !== 8'd0 ||
            out_col !== 8'd0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v %b w %h r %0d c %0d d %b rdy %b, want 0 0 0 0 0 1",
                     out_valid, out_win, out_row, out_col, frame_done, in_ready);
        end
        n_chk++;
        if (m_out_valid !== 1'b0 || m_out_win !== '0 || m_frame_done !== 1'b0 ||
            m_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_min: got v %b w %h d %b rdy %b, want 0 0 0 1",
                     m_out_valid, m_out_win, m_frame_done, m_in_ready);
        end
    endtask

    task automatic test_count_order;
        fill_img(0);
        run_frame(1'b1, 0);
    endtask

    task automatic test_orientation;
        logic [48:0] want;
        fill_img(1);
        run_frame(1'b1, 0);
        want = 49'h1 << 25;
        n_chk++;
        if (first_win !== want) begin
            n_fail++;
            $display("FAIL orientation: got %h, want %h", first_win, want);
        end
    endtask

    task automatic test_backpressure;
        fill_img(2);
        run_frame(1'b1, 5);
    endtask

    task automatic test_restart;
        int k, g;
        fill_img(0);
        k = 0;
        g = 0;
        while (k < 285 && g < 1000) begin
            cyc(1'b1, img[k/28][k%28], k == 0, 1'b1);
            if (acc) k++;
            n_chk++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL aborted_done: got 1 at pixel %0d, want 0", k);
            end
            g++;
        end
        fill_img(0);
        run_frame(1'b1, 0);
    endtask

    task automatic test_reset_mid;
        int k, g;
        fill_img(0);
        k = 0;
        g = 0;
        while (k < 296 && g < 1000) begin
            cyc(1'b1, img[k/28][k%28], k == 0, 1'b1);
            if (acc) k++;
            g++;
        end
        n_chk++;
        if (out_valid !== 1'b1 || out_row !== 8'd4 || out_col !== 8'd9) begin
            n_fail++;
            $display("FAIL pre_reset_window: got v %b r%0d c%0d, want 1 r4 c9",
                     out_valid, out_row, out_col);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %b, want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got v %b d %b rdy %b, want 0 0 1",
                     out_valid, frame_done, in_ready);
        end
        fill_img(0);
        run_frame(1'b0, 0);
    endtask

    task automatic test_min_size;
        int k, nw, nfd, g;
        bit macc;
        k = 0; nw = 0; nfd = 0; g = 0;
        while ((k < 98 || m_out_valid) && g < 500) begin
            @(negedge clk);
            m_in_valid = (k < 98);
            m_in_pix = 1'b1;
            m_in_sof = (k == 0);
            m_out_ready = 1'b1;
            #1 macc = m_in_valid && m_in_ready;
            @(posedge clk);
            #1;
            if (macc) k++;
            if (m_frame_done) nfd++;
            if (m_out_valid) begin
                nw++;
                n_chk++;
                if (m_out_win !== 49'h1_FFFF_FFFF_FFFF || m_out_row !== 8'd0 ||
                    m_out_col !== 8'd0 || m_frame_done !== 1'b1 ||
                    k !== 49 * nw) begin
                    n_fail++;
                    $display("FAIL min_window_%0d: got %h r%0d c%0d d %b k %0d, want 1ffffffffffff r0 c0 d 1 k %0d",
                             nw, m_out_win, m_out_row, m_out_col, m_frame_done, k, 49 * nw);
                end
            end
            g++;
        end
        m_in_valid = 1'b0;
        n_chk++;
        if (nw != 2 || nfd != 2) begin
            n_fail++;
            $display("FAIL min_totals: got %0d windows %0d done, want 2 2", nw, nfd);
        end
    endtask

    initial begin
        test_reset;
        test_count_order;
        test_orientation;
        test_backpressure;
        test_restart;
        test_reset_mid;
        test_min_size;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
